// File: rtl/crossbar_switch_allocator.sv
// crossbar_switch_allocator
//   Five-port (N,S,W,E,L) wormhole switch allocator. Each output port runs an
//   IDLE/LOCKED FSM with a round-robin pointer. The winning input keeps the
//   output until its tail flit transfers. The allocator drives the crossbar
//   demux/mux selects, the per-input grants and the per-output valids.
//   Optional build macro: CSA_TIMEOUT_EN. When it is defined, a locked output
//   that stalls for TIMEOUT_CYC cycles is forcibly released.
//   Port index order used internally: 0=N, 1=S, 2=W, 3=E, 4=L.
module crossbar_switch_allocator #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       n_req_i,
    input  logic       s_req_i,
    input  logic       w_req_i,
    input  logic       e_req_i,
    input  logic       l_req_i,
    input  logic [2:0] n_dest_i,
    input  logic [2:0] s_dest_i,
    input  logic [2:0] w_dest_i,
    input  logic [2:0] e_dest_i,
    input  logic [2:0] l_dest_i,
    input  logic       n_tail_i,
    input  logic       s_tail_i,
    input  logic       w_tail_i,
    input  logic       e_tail_i,
    input  logic       l_tail_i,
    input  logic       n_out_rdy_i,
    input  logic       s_out_rdy_i,
    input  logic       w_out_rdy_i,
    input  logic       e_out_rdy_i,
    input  logic       l_out_rdy_i,
    output logic       n_gnt_o,
    output logic       s_gnt_o,
    output logic       w_gnt_o,
    output logic       e_gnt_o,
    output logic       l_gnt_o,
    output logic [2:0] n_cs_sel_demux_o,
    output logic [2:0] s_cs_sel_demux_o,
    output logic [2:0] w_cs_sel_demux_o,
    output logic [2:0] e_cs_sel_demux_o,
    output logic [2:0] l_cs_sel_demux_o,
    output logic [2:0] n_cs_sel_mux_o,
    output logic [2:0] s_cs_sel_mux_o,
    output logic [2:0] w_cs_sel_mux_o,
    output logic [2:0] e_cs_sel_mux_o,
    output logic [2:0] l_cs_sel_mux_o,
    output logic       n_out_vld_o,
    output logic       s_out_vld_o,
    output logic       w_out_vld_o,
    output logic       e_out_vld_o,
    output logic       l_out_vld_o,
    output logic       err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    logic [4:0]  req;
    logic [4:0]  tail;
    logic [4:0]  out_rdy;
    logic [2:0]  dest [5];

    lock_state_t state_q [5];
    lock_state_t state_d [5];
    logic [2:0]  owner_q [5];
    logic [2:0]  owner_d [5];
    logic [2:0]  ptr_q   [5];
    logic [2:0]  ptr_d   [5];
    logic        err_q;
    logic        err_d;

    // Decoded lock view: gnt is indexed by input, the others by output.
    logic [4:0]  gnt;
    logic [4:0]  vld;
    logic [4:0]  own_req;
    logic [4:0]  own_tail;
    logic [4:0]  xfer;
    logic [2:0]  demux [5];
    logic [2:0]  mux   [5];

`ifdef CSA_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] stall_q [5];
    logic [CW-1:0] stall_d [5];
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    assign req     = {l_req_i, e_req_i, w_req_i, s_req_i, n_req_i};
    assign tail    = {l_tail_i, e_tail_i, w_tail_i, s_tail_i, n_tail_i};
    assign out_rdy = {l_out_rdy_i, e_out_rdy_i, w_out_rdy_i, s_out_rdy_i, n_out_rdy_i};
    assign dest[0] = n_dest_i;
    assign dest[1] = s_dest_i;
    assign dest[2] = w_dest_i;
    assign dest[3] = e_dest_i;
    assign dest[4] = l_dest_i;

    // Decode the registered locks into grants, selects, valids and transfers.
    always_comb begin
        gnt      = '0;
        vld      = '0;
        own_req  = '0;
        own_tail = '0;
        xfer     = '0;
        for (int unsigned o = 0; o < 5; o++) begin
            demux[o] = '0;
            mux[o]   = '0;
        end
        for (int unsigned o = 0; o < 5; o++) begin
            if (state_q[o] == LOCKED) begin
                mux[o] = owner_q[o];
                for (int unsigned i = 0; i < 5; i++) begin
                    if (owner_q[o] == 3'(i)) begin
                        gnt[i]      = 1'b1;
                        demux[i]    = 3'(o);
                        own_req[o]  = req[i];
                        own_tail[o] = tail[i];
                    end
                end
                vld[o]  = own_req[o];
                xfer[o] = own_req[o] & out_rdy[o];
            end
        end
    end

    // Next-state: round-robin arbitration in IDLE, tail/timeout release in LOCKED.
    always_comb begin
        logic        found;
        logic [2:0]  win;
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        err_d = err_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (req[i] && (dest[i] > 3'd4)) err_d = 1'b1;
        end
        for (int unsigned o = 0; o < 5; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
`ifdef CSA_TIMEOUT_EN
            stall_d[o] = stall_q[o];
`endif
        end
        for (int unsigned o = 0; o < 5; o++) begin
            found = 1'b0;
            win   = '0;
            if (state_q[o] == IDLE) begin
                // Inputs already owning any output (gnt) are excluded.
                for (int unsigned k = 1; k <= 5; k++) begin
                    idx = (32'(ptr_q[o]) + k) % 5;
                    if (!found && req[idx] && (dest[idx] == 3'(o)) && !gnt[idx]) begin
                        found = 1'b1;
                        win   = 3'(idx);
                    end
                end
                if (found) begin
                    state_d[o] = LOCKED;
                    owner_d[o] = win;
                    ptr_d[o]   = win;
                end
`ifdef CSA_TIMEOUT_EN
                stall_d[o] = '0;
`endif
            end else begin
                if (xfer[o] && own_tail[o]) state_d[o] = IDLE;
`ifdef CSA_TIMEOUT_EN
                // ptr keeps the timed-out owner so it drops to lowest priority.
                if (xfer[o]) begin
                    stall_d[o] = '0;
                end else if (stall_q[o] == CW'(TIMEOUT_CYC - 1)) begin
                    state_d[o] = IDLE;
                    stall_d[o] = '0;
                    err_d      = 1'b1;
                end else begin
                    stall_d[o] = stall_q[o] + 1'b1;
                end
`endif
            end
        end
    end

    // State registers; reset drops every lock and points each arbiter at L.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned o = 0; o < 5; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= 3'd4;
`ifdef CSA_TIMEOUT_EN
                stall_q[o] <= '0;
`endif
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned o = 0; o < 5; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
`ifdef CSA_TIMEOUT_EN
                stall_q[o] <= stall_d[o];
`endif
            end
            err_q <= err_d;
        end
    end

    assign n_gnt_o = gnt[0];
    assign s_gnt_o = gnt[1];
    assign w_gnt_o = gnt[2];
    assign e_gnt_o = gnt[3];
    assign l_gnt_o = gnt[4];

    assign n_cs_sel_demux_o = demux[0];
    assign s_cs_sel_demux_o = demux[1];
    assign w_cs_sel_demux_o = demux[2];
    assign e_cs_sel_demux_o = demux[3];
    assign l_cs_sel_demux_o = demux[4];

    assign n_cs_sel_mux_o = mux[0];
    assign s_cs_sel_mux_o = mux[1];
    assign w_cs_sel_mux_o = mux[2];
    assign e_cs_sel_mux_o = mux[3];
    assign l_cs_sel_mux_o = mux[4];

    assign n_out_vld_o = vld[0];
    assign s_out_vld_o = vld[1];
    assign w_out_vld_o = vld[2];
    assign e_out_vld_o = vld[3];
    assign l_out_vld_o = vld[4];

    assign err_o = err_q;

endmodule

// File: tb/tb_crossbar_switch_allocator.sv
// Directed testbench for crossbar_switch_allocator.
// Port index order: 0=N, 1=S, 2=W, 3=E, 4=L.
module tb_crossbar_switch_allocator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] tail = '0;
    logic [4:0] rdy = '0;
    logic [2:0] dest [5];

    logic       n_gnt, s_gnt, w_gnt, e_gnt, l_gnt;
    logic       n_vld, s_vld, w_vld, e_vld, l_vld;
    logic [2:0] demux [5];
    logic [2:0] mux   [5];
    logic       err;
    logic [4:0] gnt;
    logic [4:0] vld;

    int checks = 0;
    int errors = 0;

    // Test 3 vectors: inputs applied in a cycle, expected grant/L-mux next cycle.
    logic [4:0] t3_req  [10] = '{5'b01110, 5'b01110, 5'b01110, 5'b01100, 5'b01100,
                                 5'b01100, 5'b01000, 5'b01000, 5'b01000, 5'b01001};
    logic [4:0] t3_tail [10] = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 5'b00000,
                                 5'b00100, 5'b00000, 5'b00000, 5'b01000, 5'b00000};
    logic [4:0] t3_gnt  [10] = '{5'b00010, 5'b00010, 5'b00000, 5'b00100, 5'b00100,
                                 5'b00000, 5'b01000, 5'b01000, 5'b00000, 5'b00001};
    logic [2:0] t3_mux  [10] = '{3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd0, 3'd3, 3'd3, 3'd0, 3'd0};

    assign gnt = {l_gnt, e_gnt, w_gnt, s_gnt, n_gnt};
    assign vld = {l_vld, e_vld, w_vld, s_vld, n_vld};

    always #5 clk = ~clk;

    crossbar_switch_allocator #(.TIMEOUT_CYC(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .n_req_i          (req[0]),
        .s_req_i          (req[1]),
        .w_req_i          (req[2]),
        .e_req_i          (req[3]),
        .l_req_i          (req[4]),
        .n_dest_i         (dest[0]),
        .s_dest_i         (dest[1]),
        .w_dest_i         (dest[2]),
        .e_dest_i         (dest[3]),
        .l_dest_i         (dest[4]),
        .n_tail_i         (tail[0]),
        .s_tail_i         (tail[1]),
        .w_tail_i         (tail[2]),
        .e_tail_i         (tail[3]),
        .l_tail_i         (tail[4]),
        .n_out_rdy_i      (rdy[0]),
        .s_out_rdy_i      (rdy[1]),
        .w_out_rdy_i      (rdy[2]),
        .e_out_rdy_i      (rdy[3]),
        .l_out_rdy_i      (rdy[4]),
        .n_gnt_o          (n_gnt),
        .s_gnt_o          (s_gnt),
        .w_gnt_o          (w_gnt),
        .e_gnt_o          (e_gnt),
        .l_gnt_o          (l_gnt),
        .n_cs_sel_demux_o (demux[0]),
        .s_cs_sel_demux_o (demux[1]),
        .w_cs_sel_demux_o (demux[2]),
        .e_cs_sel_demux_o (demux[3]),
        .l_cs_sel_demux_o (demux[4]),
        .n_cs_sel_mux_o   (mux[0]),
        .s_cs_sel_mux_o   (mux[1]),
        .w_cs_sel_mux_o   (mux[2]),
        .e_cs_sel_mux_o   (mux[3]),
        .l_cs_sel_mux_o   (mux[4]),
        .n_out_vld_o      (n_vld),
        .s_out_vld_o      (s_vld),
        .w_out_vld_o      (w_vld),
        .e_out_vld_o      (e_vld),
        .l_out_vld_o      (l_vld),
        .err_o            (err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from a clock edge, check outputs before any edge, then release.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_vld"}, 32'(vld), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_sel"}, 32'({demux[0], demux[1], demux[2], demux[3], demux[4],
                                  mux[0], mux[1], mux[2], mux[3], mux[4]}), 0);
        req  = '0;
        tail = '0;
        rdy  = '0;
        for (int i = 0; i < 5; i++) dest[i] = 3'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 5; i++) dest[i] = 3'd0;
        #2;
        do_reset("rst0");

        // Test 2: single N->L packet, 1-cycle grant latency, tail release.
        req[0]  = 1'b1;
        dest[0] = 3'd4;
        rdy[4]  = 1'b1;
        #1;
        check("t2_lat_gnt", 32'(gnt), 0);
        tick();
        check("t2_gnt",   32'(gnt), 'b00001);
        check("t2_demux", 32'(demux[0]), 4);
        check("t2_mux",   32'(mux[4]), 0);
        check("t2_vld",   32'(vld), 'b10000);
        tick();
        check("t2_c2_gnt", 32'(gnt), 'b00001);
        tick();
        tail[0] = 1'b1;
        check("t2_c3_gnt", 32'(gnt), 'b00001);
        tick();
        req[0]  = 1'b0;
        tail[0] = 1'b0;
        check("t2_c4_gnt", 32'(gnt), 0);
        check("t2_c4_vld", 32'(vld), 0);
        tick();
        check("t2_c5_gnt", 32'(gnt), 0);

        // Test 3: S, W, E contend for L with 2-flit packets.
        do_reset("rst3");
        for (int i = 0; i < 5; i++) dest[i] = 3'd4;
        rdy[4] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req  = t3_req[c];
            tail = t3_tail[c];
            tick();
            check($sformatf("t3_gnt_c%0d", c + 1), 32'(gnt), 32'(t3_gnt[c]));
            check($sformatf("t3_mux_c%0d", c + 1), 32'(mux[4]), 32'(t3_mux[c]));
            check($sformatf("t3_vld_c%0d", c + 1), 32'(vld),
                  (t3_gnt[c] != 5'b0) ? 'b10000 : 0);
        end

        // Test 4: disjoint requests all granted in parallel.
        do_reset("rst4");
        dest[0] = 3'd3;
        dest[1] = 3'd2;
        dest[4] = 3'd0;
        req     = 5'b10011;
        tick();
        check("t4_gnt",   32'(gnt), 'b10011);
        check("t4_emux",  32'(mux[3]), 0);
        check("t4_wmux",  32'(mux[2]), 1);
        check("t4_nmux",  32'(mux[0]), 4);
        check("t4_ndmx",  32'(demux[0]), 3);
        check("t4_sdmx",  32'(demux[1]), 2);
        check("t4_ldmx",  32'(demux[4]), 0);
        check("t4_vld",   32'(vld), 'b01101);
        dest[0] = 3'd1;
        tick();
        check("t4_dchg_dmx", 32'(demux[0]), 3);
        check("t4_dchg_gnt", 32'(gnt), 'b10011);
        check("t4_dchg_vld", 32'(vld), 'b01101);

        // Test 1: reset mid-run with three locks held.
        do_reset("t1");

        // Test 5: out_rdy low holds the lock despite tail.
        req[0]  = 1'b1;
        dest[0] = 3'd4;
        tail[0] = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t5_hold_gnt%0d", c), 32'(gnt), 'b00001);
            check($sformatf("t5_hold_vld%0d", c), 32'(vld), 'b10000);
            tick();
        end
        rdy[4] = 1'b1;
        #1;
        check("t5_pre_gnt", 32'(gnt), 'b00001);
        tick();
        check("t5_rel_gnt", 32'(gnt), 0);
        req[0] = 1'b0;
        tick();
        check("t5_idle_gnt", 32'(gnt), 0);

        // Test 6: illegal dest is never granted and sets sticky err.
        do_reset("rst6");
        req[2]  = 1'b1;
        dest[2] = 3'd5;
        #1;
        check("t6_err_pre", 32'(err), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t6_gnt%0d", c), 32'(gnt), 0);
            check($sformatf("t6_err%0d", c), 32'(err), 1);
        end
        req[2] = 1'b0;
        tick();
        check("t6_err_sticky", 32'(err), 1);
        // U-turn E->E is arbitrated normally.
        req[3]  = 1'b1;
        dest[3] = 3'd3;
        tick();
        check("t6_uturn_gnt", 32'(gnt), 'b01000);
        check("t6_uturn_mux", 32'(mux[3]), 3);
        check("t6_uturn_dmx", 32'(demux[3]), 3);
        do_reset("t6_clr");

`ifdef CSA_TIMEOUT_EN
        // Timeout: 4 stalled locked cycles force a release and set err.
        req[0]  = 1'b1;
        dest[0] = 3'd4;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("to_gnt%0d", c), 32'(gnt), 'b00001);
            check($sformatf("to_err%0d", c), 32'(err), 0);
        end
        req[0] = 1'b0;
        tick();
        check("to_rel_gnt", 32'(gnt), 0);
        check("to_err",     32'(err), 1);
        do_reset("to_clr");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
